// File: rtl/fan_pkg.sv
// Shared types and constants for the fan mode controller and its display helpers.
// Level and timer-preset encodings, preset durations and default duty values.
package fan_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } level_e;

  typedef enum logic [1:0] {
    PRE_NONE = 2'd0,
    PRE_60   = 2'd1,
    PRE_180  = 2'd2,
    PRE_300  = 2'd3
  } preset_e;

  localparam logic [8:0] PRESET_60_S  = 9'd60;
  localparam logic [8:0] PRESET_180_S = 9'd180;
  localparam logic [8:0] PRESET_300_S = 9'd300;

  localparam logic [7:0] DUTY_L1_DEF = 8'd85;
  localparam logic [7:0] DUTY_L2_DEF = 8'd170;
  localparam logic [7:0] DUTY_L3_DEF = 8'd255;

  // The speed button cycles LOW/MID/HIGH and never returns to OFF.
  function automatic level_e next_level(input level_e lvl);
    case (lvl)
      LVL_OFF: next_level = LVL_LOW;
      LVL_LOW: next_level = LVL_MID;
      LVL_MID: next_level = LVL_HIGH;
      default: next_level = LVL_LOW;
    endcase
  endfunction

  function automatic preset_e next_preset(input preset_e pre);
    case (pre)
      PRE_NONE: next_preset = PRE_60;
      PRE_60:   next_preset = PRE_180;
      PRE_180:  next_preset = PRE_300;
      default:  next_preset = PRE_NONE;
    endcase
  endfunction

  function automatic logic [8:0] preset_seconds(input preset_e pre);
    case (pre)
      PRE_60:  preset_seconds = PRESET_60_S;
      PRE_180: preset_seconds = PRESET_180_S;
      PRE_300: preset_seconds = PRESET_300_S;
      default: preset_seconds = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// One-second prescaler: counts 0..TICK_CYCLES-1 while enabled and emits a one-cycle
// tick on the wrap. Held at 0 while disabled; i_restart reloads 0 synchronously.
module fan_tick_gen #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned    CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (i_restart || !i_en) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign o_tick = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fan_mode_controller.sv
// Fan level FSM, duty target and auto-off countdown driven by debounced button pulses.
// Optional soft start of the duty output is built when FAN_SOFT_START_EN is defined.
module fan_mode_controller
  import fan_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter logic [7:0]  DUTY_L1     = DUTY_L1_DEF,
  parameter logic [7:0]  DUTY_L2     = DUTY_L2_DEF,
  parameter logic [7:0]  DUTY_L3     = DUTY_L3_DEF
`ifdef FAN_SOFT_START_EN
  , parameter int unsigned RAMP_CYCLES = 1000
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_speed,
  input  logic       i_btn_timer,
  input  logic       i_btn_off,
  output logic [1:0] o_level,
  output logic [7:0] o_duty,
  output logic       o_run,
  output logic       o_timer_on,
  output logic [8:0] o_timer_remain
);

  level_e     level_q, level_d;
  preset_e    preset_q, preset_d;
  logic [8:0] remain_q, remain_d;
  logic       run_q, timer_on_q;
  logic [7:0] duty_q, target_d;
  logic       tick, restart, expire;

  function automatic logic [7:0] duty_for(input level_e lvl);
    case (lvl)
      LVL_LOW:  duty_for = DUTY_L1;
      LVL_MID:  duty_for = DUTY_L2;
      LVL_HIGH: duty_for = DUTY_L3;
      default:  duty_for = 8'd0;
    endcase
  endfunction

  fan_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (preset_q != PRE_NONE),
    .i_restart (restart),
    .o_tick    (tick)
  );

  // Off pulse beats expiry, which beats speed/timer; speed and timer both see pre-edge state.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    level_d  = level_q;
    preset_d = preset_q;
    remain_d = remain_q;
    restart  = 1'b0;
    expire   = tick && (preset_q != PRE_NONE) && (remain_q == 9'd1);

    if (i_btn_off || expire) begin
      level_d  = LVL_OFF;
      preset_d = PRE_NONE;
      remain_d = 9'd0;
      restart  = 1'b1;
    end else begin
      if (i_btn_speed) begin
        level_d = next_level(level_q);
      end
      if (i_btn_timer && (level_q != LVL_OFF)) begin
        preset_d = next_preset(preset_q);
        remain_d = preset_seconds(preset_d);
        restart  = 1'b1;
      end else if (tick && (preset_q != PRE_NONE)) begin
        remain_d = remain_q - 9'd1;
      end
    end
  end

  assign target_d = duty_for(level_d);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q    <= LVL_OFF;
      preset_q   <= PRE_NONE;
      remain_q   <= 9'd0;
      run_q      <= 1'b0;
      timer_on_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      preset_q   <= preset_d;
      remain_q   <= remain_d;
      run_q      <= (level_d != LVL_OFF);
      timer_on_q <= (preset_d != PRE_NONE);
    end
  end

`ifdef FAN_SOFT_START_EN
  localparam int unsigned      RAMP_W    = $clog2(RAMP_CYCLES + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);

  logic [RAMP_W-1:0] ramp_q;

  // Downward moves are immediate; upward moves climb one step per RAMP_CYCLES.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      duty_q <= 8'd0;
      ramp_q <= '0;
    end else if (target_d <= duty_q) begin
      duty_q <= target_d;
      ramp_q <= '0;
    end else if (target_d != duty_for(level_q)) begin
      ramp_q <= '0;
    end else if (ramp_q == RAMP_LAST) begin
      duty_q <= duty_q + 8'd1;
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_q + RAMP_ONE;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      duty_q <= 8'd0;
    end else begin
      duty_q <= target_d;
    end
  end
`endif

  assign o_level        = level_q;
  assign o_duty         = duty_q;
  assign o_run          = run_q;
  assign o_timer_on     = timer_on_q;
  assign o_timer_remain = remain_q;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Directed bench for fan_mode_controller with TICK_CYCLES=10, RAMP_CYCLES=4.
// Soft-start checks are compiled in when FAN_SOFT_START_EN is defined.
module tb_fan_mode_controller;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_btn_speed = 1'b0;
  logic       i_btn_timer = 1'b0;
  logic       i_btn_off = 1'b0;
  logic [1:0] o_level;
  logic [7:0] o_duty;
  logic       o_run;
  logic       o_timer_on;
  logic [8:0] o_timer_remain;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  fan_mode_controller #(
`ifdef FAN_SOFT_START_EN
    .RAMP_CYCLES (4),
`endif
    .TICK_CYCLES (10),
    .DUTY_L1     (8'd85),
    .DUTY_L2     (8'd170),
    .DUTY_L3     (8'd255)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_btn_speed    (i_btn_speed),
    .i_btn_timer    (i_btn_timer),
    .i_btn_off      (i_btn_off),
    .o_level        (o_level),
    .o_duty         (o_duty),
    .o_run          (o_run),
    .o_timer_on     (o_timer_on),
    .o_timer_remain (o_timer_remain)
  );

  // One-cycle pulse sampled on the next rising edge; returns on the following falling edge.
  task automatic pulse(input logic spd, input logic tmr, input logic off);
    @(negedge i_clk);
    i_btn_speed = spd;
    i_btn_timer = tmr;
    i_btn_off   = off;
    @(negedge i_clk);
    i_btn_speed = 1'b0;
    i_btn_timer = 1'b0;
    i_btn_off   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_level, o_duty, o_run, o_timer_on, o_timer_remain} !== 21'd0) begin
      bad++;
      $display("FAIL reset_state: got lvl=%0d duty=%0d run=%0d on=%0d rem=%0d, want all 0",
               o_level, o_duty, o_run, o_timer_on, o_timer_remain);
    end
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_speed_cycle();
    logic [1:0] exp_lvl  [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] exp_duty [4] = '{8'd85, 8'd170, 8'd255, 8'd85};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      total++;
      if (o_level !== exp_lvl[i] || o_run !== 1'b1) begin
        bad++;
        $display("FAIL speed_level[%0d]: got lvl=%0d run=%0d, want lvl=%0d run=1",
                 i, o_level, o_run, exp_lvl[i]);
      end
`ifndef FAN_SOFT_START_EN
      total++;
      if (o_duty !== exp_duty[i]) begin
        bad++;
        $display("FAIL speed_duty[%0d]: got %0d want %0d", i, o_duty, exp_duty[i]);
      end
`endif
    end
  endtask

  task automatic test_timer_expiry();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (o_timer_on !== 1'b1 || o_timer_remain !== 9'd60) begin
      bad++;
      $display("FAIL timer_load: got on=%0d rem=%0d, want on=1 rem=60", o_timer_on, o_timer_remain);
    end
    repeat (9) @(negedge i_clk);
    total++;
    if (o_timer_remain !== 9'd60) begin
      bad++;
      $display("FAIL tick_early: got rem=%0d want 60", o_timer_remain);
    end
    @(negedge i_clk);
    total++;
    if (o_timer_remain !== 9'd59) begin
      bad++;
      $display("FAIL tick_first: got rem=%0d want 59", o_timer_remain);
    end
    repeat (589) @(negedge i_clk);
    total++;
    if (o_timer_remain !== 9'd1 || o_level !== 2'd1) begin
      bad++;
      $display("FAIL pre_expiry: got rem=%0d lvl=%0d, want rem=1 lvl=1", o_timer_remain, o_level);
    end
    @(negedge i_clk);
    total++;
    if ({o_level, o_duty, o_run, o_timer_on, o_timer_remain} !== 21'd0) begin
      bad++;
      $display("FAIL expiry: got lvl=%0d duty=%0d run=%0d on=%0d rem=%0d, want all 0",
               o_level, o_duty, o_run, o_timer_on, o_timer_remain);
    end
  endtask

  task automatic test_timer_presets();
    logic [8:0] exp_rem [4] = '{9'd60, 9'd180, 9'd300, 9'd0};
    logic       exp_on  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (o_level !== 2'd0 || o_timer_on !== 1'b0 || o_timer_remain !== 9'd0) begin
      bad++;
      $display("FAIL timer_while_off: got lvl=%0d on=%0d rem=%0d, want 0/0/0",
               o_level, o_timer_on, o_timer_remain);
    end
    pulse(1'b1, 1'b1, 1'b0);
    total++;
    if (o_level !== 2'd1 || o_timer_on !== 1'b0 || o_timer_remain !== 9'd0) begin
      bad++;
      $display("FAIL speed_timer_from_off: got lvl=%0d on=%0d rem=%0d, want 1/0/0",
               o_level, o_timer_on, o_timer_remain);
    end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      total++;
      if (o_timer_remain !== exp_rem[i] || o_timer_on !== exp_on[i]) begin
        bad++;
        $display("FAIL preset[%0d]: got rem=%0d on=%0d, want rem=%0d on=%0d",
                 i, o_timer_remain, o_timer_on, exp_rem[i], exp_on[i]);
      end
    end
  endtask

  task automatic test_off_priority();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (550) @(negedge i_clk);
    total++;
    if (o_timer_remain !== 9'd5) begin
      bad++;
      $display("FAIL remain_5: got rem=%0d want 5", o_timer_remain);
    end
    pulse(1'b1, 1'b0, 1'b1);
    total++;
    if (o_level !== 2'd0 || o_run !== 1'b0 || o_timer_on !== 1'b0 || o_timer_remain !== 9'd0) begin
      bad++;
      $display("FAIL off_beats_speed: got lvl=%0d run=%0d on=%0d rem=%0d, want all 0",
               o_level, o_run, o_timer_on, o_timer_remain);
    end
  endtask

  task automatic test_expiry_vs_speed();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (599) @(negedge i_clk);
    total++;
    if (o_timer_remain !== 9'd1) begin
      bad++;
      $display("FAIL before_expiry: got rem=%0d want 1", o_timer_remain);
    end
    i_btn_speed = 1'b1;
    @(negedge i_clk);
    i_btn_speed = 1'b0;
    total++;
    if (o_level !== 2'd0 || o_timer_on !== 1'b0 || o_timer_remain !== 9'd0) begin
      bad++;
      $display("FAIL expiry_beats_speed: got lvl=%0d on=%0d rem=%0d, want 0/0/0",
               o_level, o_timer_on, o_timer_remain);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (25) @(negedge i_clk);
    total++;
    if (o_level !== 2'd2 || o_timer_remain !== 9'd58) begin
      bad++;
      $display("FAIL mid_countdown: got lvl=%0d rem=%0d, want lvl=2 rem=58", o_level, o_timer_remain);
    end
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    total++;
    if ({o_level, o_duty, o_run, o_timer_on, o_timer_remain} !== 21'd0) begin
      bad++;
      $display("FAIL async_reset: got lvl=%0d duty=%0d run=%0d on=%0d rem=%0d, want all 0",
               o_level, o_duty, o_run, o_timer_on, o_timer_remain);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    total++;
    if ({o_level, o_duty, o_run, o_timer_on, o_timer_remain} !== 21'd0) begin
      bad++;
      $display("FAIL after_reset_release: got lvl=%0d duty=%0d on=%0d rem=%0d, want all 0",
               o_level, o_duty, o_timer_on, o_timer_remain);
    end
  endtask

`ifdef FAN_SOFT_START_EN
  task automatic test_soft_start();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (o_level !== 2'd1 || o_duty !== 8'd0) begin
      bad++;
      $display("FAIL ramp_start: got lvl=%0d duty=%0d, want lvl=1 duty=0", o_level, o_duty);
    end
    repeat (339) @(negedge i_clk);
    total++;
    if (o_duty !== 8'd84) begin
      bad++;
      $display("FAIL ramp_339: got duty=%0d want 84", o_duty);
    end
    @(negedge i_clk);
    total++;
    if (o_duty !== 8'd85) begin
      bad++;
      $display("FAIL ramp_340: got duty=%0d want 85", o_duty);
    end
    repeat (8) @(negedge i_clk);
    total++;
    if (o_duty !== 8'd85) begin
      bad++;
      $display("FAIL ramp_hold: got duty=%0d want 85", o_duty);
    end
    pulse(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge i_clk);
    total++;
    if (o_level !== 2'd2 || o_duty !== 8'd90) begin
      bad++;
      $display("FAIL ramp_mid: got lvl=%0d duty=%0d, want lvl=2 duty=90", o_level, o_duty);
    end
    pulse(1'b0, 1'b0, 1'b1);
    total++;
    if (o_duty !== 8'd0 || o_level !== 2'd0) begin
      bad++;
      $display("FAIL ramp_off: got lvl=%0d duty=%0d, want 0/0", o_level, o_duty);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_speed_cycle();
    test_timer_expiry();
    test_timer_presets();
    test_off_priority();
    test_expiry_vs_speed();
    test_async_reset();
`ifdef FAN_SOFT_START_EN
    test_soft_start();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
